// File: rtl/sim_ctrl_pkg.sv
// Shared types and default parameters for the simulation run sequencer.
package sim_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSTH = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_e;

    typedef enum logic [1:0] {
        ST_NONE    = 2'd0,
        ST_PASS    = 2'd1,
        ST_TIMEOUT = 2'd2,
        ST_ABORT   = 2'd3
    } run_status_e;

    localparam int unsigned DEF_RESET_CYCLES = 2;
    localparam int unsigned DEF_MAX_CYCLES   = 11;
    localparam int unsigned DEF_CNT_W        = 16;

endpackage

// File: rtl/sat_cycle_counter.sv
// Clear/enable up-counter that saturates at all-ones and flags a fixed terminal count.
module sat_cycle_counter #(
    parameter int unsigned Width    = 16,
    parameter int unsigned Terminal = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o,
    output logic             at_tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign at_tc_o = (cnt_q == Width'(Terminal));

endmodule

// File: rtl/sim_run_controller.sv
// Run sequencer: holds the DUT in reset, enables it, and ends the run on done, budget or abort.
module sim_run_controller
    import sim_ctrl_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_done,
    output logic             dut_reset,
    output logic             dut_run,
    output logic             busy,
    output logic             status_valid,
    output logic             pass,
    output logic             timeout,
    output logic             aborted,
    output logic [CNT_W-1:0] cycle_count
);

    if (RESET_CYCLES < 1 || MAX_CYCLES < 1 ||
        64'(MAX_CYCLES) >= (64'd1 << CNT_W)) begin : gen_param_err
        $error("sim_run_controller: illegal RESET_CYCLES/MAX_CYCLES/CNT_W combination");
    end

    run_state_e  state_q, state_d;
    run_status_e status_q, status_d;

    logic             cnt_clr;
    logic             rst_cnt_en, run_cnt_en;
    logic             rst_at_tc, run_at_tc;
    logic [CNT_W-1:0] rst_cnt;
    logic             unused_rst_cnt;

    assign unused_rst_cnt = ^rst_cnt;
    assign rst_cnt_en     = (state_q == RSTH);
    assign run_cnt_en     = (state_q == RUN);

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cnt_clr  = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                // Restart from DONE skips IDLE; both clear counters and status.
                if (start) begin
                    state_d  = RSTH;
                    status_d = ST_NONE;
                    cnt_clr  = 1'b1;
                end
            end
            RSTH: begin
                if (abort) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end else if (rst_at_tc) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // The run counter increments on every RUN cycle, including the final one.
                if (dut_done) begin
                    state_d  = DONE;
                    status_d = ST_PASS;
                end else if (abort) begin
                    state_d  = DONE;
                    status_d = ST_ABORT;
                end else if (run_at_tc) begin
                    state_d  = DONE;
                    status_d = ST_TIMEOUT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            status_q <= ST_NONE;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    sat_cycle_counter #(
        .Width    (CNT_W),
        .Terminal (RESET_CYCLES - 1)
    ) u_rst_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (cnt_clr),
        .en_i    (rst_cnt_en),
        .cnt_o   (rst_cnt),
        .at_tc_o (rst_at_tc)
    );

    sat_cycle_counter #(
        .Width    (CNT_W),
        .Terminal (MAX_CYCLES - 1)
    ) u_run_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (cnt_clr),
        .en_i    (run_cnt_en),
        .cnt_o   (cycle_count),
        .at_tc_o (run_at_tc)
    );

    assign dut_reset    = (state_q == IDLE) || (state_q == RSTH);
    assign dut_run      = (state_q == RUN);
    assign busy         = (state_q == RSTH) || (state_q == RUN);
    assign status_valid = (state_q == DONE);
    assign pass         = (status_q == ST_PASS);
    assign timeout      = (status_q == ST_TIMEOUT);
    assign aborted      = (status_q == ST_ABORT);

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller with default parameters (RESET_CYCLES=2, MAX_CYCLES=11).
module tb_sim_run_controller;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic        dut_done;
    logic        dut_reset;
    logic        dut_run;
    logic        busy;
    logic        status_valid;
    logic        pass;
    logic        timeout;
    logic        aborted;
    logic [15:0] cycle_count;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] OutIdle = 4'b1000;  // {dut_reset, dut_run, busy, status_valid}
    localparam logic [3:0] OutRsth = 4'b1010;
    localparam logic [3:0] OutRun  = 4'b0110;
    localparam logic [3:0] OutDone = 4'b0001;

    sim_run_controller u_dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .dut_done     (dut_done),
        .dut_reset    (dut_reset),
        .dut_run      (dut_run),
        .busy         (busy),
        .status_valid (status_valid),
        .pass         (pass),
        .timeout      (timeout),
        .aborted      (aborted),
        .cycle_count  (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] exp);
        chk({tag, ".outs"}, {28'd0, dut_reset, dut_run, busy, status_valid}, {28'd0, exp});
    endtask

    // exp_flags = {pass, timeout, aborted}
    task automatic chk_status(input string tag, input logic [2:0] exp_flags,
                              input logic [15:0] exp_cnt);
        chk({tag, ".flags"}, {29'd0, pass, timeout, aborted}, {29'd0, exp_flags});
        chk({tag, ".count"}, {16'd0, cycle_count}, {16'd0, exp_cnt});
    endtask

    // Start a run from IDLE/DONE and step through both RSTH cycles into RUN cycle 1.
    task automatic launch(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_outs({tag, ".rsth1"}, OutRsth);
        chk_status({tag, ".rsth1"}, 3'b000, 16'd0);
        tick();
        chk_outs({tag, ".rsth2"}, OutRsth);
        tick();
        chk_outs({tag, ".run1"}, OutRun);
        chk_status({tag, ".run1"}, 3'b000, 16'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        dut_done = 1'b0;
        tick();
        tick();
        chk_outs("reset", OutIdle);
        chk_status("reset", 3'b000, 16'd0);
        reset = 1'b0;
        tick();
        chk_outs("idle", OutIdle);

        // 1: done on the 5th RUN cycle
        launch("t1");
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_outs("t1.run", OutRun);
            chk("t1.cnt", {16'd0, cycle_count}, i);
        end
        dut_done = 1'b1;
        tick();
        dut_done = 1'b0;
        chk_outs("t1.done", OutDone);
        chk_status("t1.done", 3'b100, 16'd5);

        // 2: budget expires after exactly 11 RUN cycles
        launch("t2");
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_outs("t2.run", OutRun);
            chk("t2.cnt", {16'd0, cycle_count}, i);
        end
        tick();
        chk_outs("t2.done", OutDone);
        chk_status("t2.done", 3'b010, 16'd11);

        // 3: done on the final budget cycle is a pass
        launch("t3");
        for (int i = 1; i <= 10; i++) tick();
        chk_outs("t3.run11", OutRun);
        dut_done = 1'b1;
        tick();
        dut_done = 1'b0;
        chk_outs("t3.done", OutDone);
        chk_status("t3.done", 3'b100, 16'd11);

        // 4a: abort on the last RSTH cycle beats the RUN exit
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk_outs("t4a.rsth2", OutRsth);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_outs("t4a.done", OutDone);
        chk_status("t4a.done", 3'b001, 16'd0);

        // 4b: abort together with done in RUN cycle 3 -> pass
        launch("t4b");
        tick();
        tick();
        dut_done = 1'b1;
        abort    = 1'b1;
        tick();
        dut_done = 1'b0;
        abort    = 1'b0;
        chk_outs("t4b.done", OutDone);
        chk_status("t4b.done", 3'b100, 16'd3);

        // 5: start while running is ignored; abort in DONE is ignored; restart from DONE
        launch("t5");
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_outs("t5.startbusy", OutRun);
        chk("t5.cnt2", {16'd0, cycle_count}, 32'd2);
        tick();
        dut_done = 1'b1;
        tick();
        dut_done = 1'b0;
        chk_status("t5.done", 3'b100, 16'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_outs("t5.abortdone", OutDone);
        chk_status("t5.abortdone", 3'b100, 16'd4);
        launch("t5r");

        // 6: reset on RUN cycle 4, with start held during reset
        tick();
        tick();
        tick();
        chk("t6.cnt3", {16'd0, cycle_count}, 32'd3);
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk_outs("t6.rst", OutIdle);
        chk_status("t6.rst", 3'b000, 16'd0);
        tick();
        chk_outs("t6.rststart", OutIdle);
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_outs("t6.abortidle", OutIdle);
        chk_status("t6.abortidle", 3'b000, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
